// File: rtl/vote_display_scheduler_if.sv
// Bus between the vote display scheduler and its surroundings: the vote
// counter bank, the shared binary-to-BCD converter and the 7-segment driver.
// The scheduler connects through the slave modport. The environment (counters,
// converter, display driver) connects through the master modport.
interface vote_display_scheduler_if #(
    parameter int NUM_CAND = 4
);
    logic [NUM_CAND*8-1:0] vote_count;
    logic                  hold;
    logic [7:0]            conv_bin;
    logic [3:0]            conv_hundreds;
    logic [3:0]            conv_tens;
    logic [3:0]            conv_ones;
    logic [3:0]            cand_idx;
    logic [3:0]            digit_sel;
    logic [3:0]            digit_bcd;
    logic                  frame_done;

    modport master (
        output vote_count, hold, conv_hundreds, conv_tens, conv_ones,
        input  conv_bin, cand_idx, digit_sel, digit_bcd, frame_done
    );

    modport slave (
        input  vote_count, hold, conv_hundreds, conv_tens, conv_ones,
        output conv_bin, cand_idx, digit_sel, digit_bcd, frame_done
    );
endinterface

// File: rtl/vote_display_scheduler.sv
// Round-robin scheduler that shares one binary-to-BCD converter among
// NUM_CAND 8-bit vote counters. It shows each candidate for a fixed dwell and
// drives a multiplexed 4-digit display: candidate number, hundreds, tens, ones.
// Optional feature macro: LEADING_ZERO_BLANK_EN blanks leading zeros in the
// hundreds and tens digits. The digit value is still driven on digit_bcd.
module vote_display_scheduler #(
    parameter int NUM_CAND     = 4,
    parameter int DWELL_CYCLES = 50000000,
    parameter int SCAN_DIV     = 50000
) (
    input logic                     clk,
    input logic                     rst,
    vote_display_scheduler_if.slave bus
);
    localparam int         DWELL_W   = $clog2(DWELL_CYCLES + 1);
    localparam int         SCAN_W    = $clog2(SCAN_DIV + 1);
    localparam logic [3:0] LAST_CAND = 4'(NUM_CAND - 1);

    typedef enum logic [1:0] {LOAD, CAPTURE, SHOW} state_t;

    state_t             state;
    logic [3:0]         cand_idx;
    logic [7:0]         conv_bin;
    logic [DWELL_W-1:0] dwell_cnt;
    logic               frame_done;
    logic [3:0]         hundreds_reg;
    logic [3:0]         tens_reg;
    logic [3:0]         ones_reg;
    logic [3:0]         cand_reg;
    logic [SCAN_W-1:0]  scan_cnt;
    logic [1:0]         scan_digit;
    logic [3:0]         digit_sel;
    logic [3:0]         digit_bcd;

    logic [7:0]         sel_count;
    logic [3:0]         hundreds_next;
    logic [3:0]         tens_next;
    logic [3:0]         ones_next;
    logic [3:0]         cand_next;
    logic [1:0]         scan_next;
    logic [3:0]         sel_next;
    logic [3:0]         bcd_next;

    assign bus.conv_bin   = conv_bin;
    assign bus.cand_idx   = cand_idx;
    assign bus.digit_sel  = digit_sel;
    assign bus.digit_bcd  = digit_bcd;
    assign bus.frame_done = frame_done;

    // Pick the current candidate's count out of the packed counter bank
    always_comb begin
        sel_count = '0;
        for (int k = 0; k < NUM_CAND; k++) begin
            if (cand_idx == 4'(k)) begin
                sel_count = bus.vote_count[8*k +: 8];
            end
        end
    end

    // Next display and scan values. The registered digit outputs follow these, so a capture reaches digit_bcd right after CAPTURE.
    always_comb begin
        hundreds_next = hundreds_reg;
        tens_next     = tens_reg;
        ones_next     = ones_reg;
        cand_next     = cand_reg;
        if (state == CAPTURE) begin
            hundreds_next = bus.conv_hundreds;
            tens_next     = bus.conv_tens;
            ones_next     = bus.conv_ones;
            cand_next     = cand_idx + 4'd1;
        end

        scan_next = scan_digit;
        if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            scan_next = scan_digit + 2'd1;
        end

        case (scan_next)
            2'd0:    bcd_next = ones_next;
            2'd1:    bcd_next = tens_next;
            2'd2:    bcd_next = hundreds_next;
            default: bcd_next = cand_next;
        endcase

        sel_next = ~(4'b0001 << scan_next);
`ifdef LEADING_ZERO_BLANK_EN
        if ((scan_next == 2'd2 && hundreds_next == 4'd0) ||
            (scan_next == 2'd1 && hundreds_next == 4'd0 && tens_next == 4'd0)) begin
            sel_next = 4'b1111;
        end
`endif
    end

    // Candidate sequencer: LOAD the operand, CAPTURE the converter result, then SHOW for the dwell time
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= LOAD;
            cand_idx   <= '0;
            conv_bin   <= '0;
            dwell_cnt  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                LOAD: begin
                    conv_bin <= sel_count;
                    state    <= CAPTURE;
                end
                CAPTURE: begin
                    dwell_cnt <= '0;
                    state     <= SHOW;
                end
                SHOW: begin
                    if (dwell_cnt == DWELL_W'(DWELL_CYCLES - 1)) begin
                        dwell_cnt <= '0;
                        state     <= LOAD;
                        if (!bus.hold) begin
                            if (cand_idx == LAST_CAND) begin
                                cand_idx   <= '0;
                                frame_done <= 1'b1;
                            end else begin
                                cand_idx <= cand_idx + 4'd1;
                            end
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + DWELL_W'(1);
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    // Display registers hold the last captured value so the display does not flicker during LOAD/CAPTURE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hundreds_reg <= '0;
            tens_reg     <= '0;
            ones_reg     <= '0;
            cand_reg     <= '0;
        end else begin
            hundreds_reg <= hundreds_next;
            tens_reg     <= tens_next;
            ones_reg     <= ones_next;
            cand_reg     <= cand_next;
        end
    end

    // Free-running digit scan, independent of the candidate sequencer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt   <= '0;
            scan_digit <= '0;
            digit_sel  <= 4'b1110;
            digit_bcd  <= '0;
        end else begin
            if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
            end else begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
            end
            scan_digit <= scan_next;
            digit_sel  <= sel_next;
            digit_bcd  <= bcd_next;
        end
    end
endmodule
